// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// State encoding, default width and counter sizing helper.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell, the borrow twin of the full adder.
// Computes x - y - bin as a difference bit and a borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Valid/ready on both sides; result held in DONE until taken.
module serial_sub4
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bin_q, bin_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             d_bit, b_out;

  full_subtractor u_fs (
    .x   (sa_q[0]),
    .y   (sb_q[0]),
    .bin (bin_q),
    .d   (d_bit),
    .bout(b_out)
  );

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) | (state_q == DONE);
  assign diff      = diff_q;
  assign borrow    = brw_q;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    diff_d  = diff_q;
    bin_d   = bin_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // new bit enters at the MSB so LSB-first bits land in place
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        sa_d   = sa_q >> 1;
        sb_d   = sb_q >> 1;
        bin_d  = b_out;
        brw_d  = b_out;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      diff_q  <= '0;
      bin_q   <= 1'b0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      diff_q  <= diff_d;
      bin_q   <= bin_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_sub4.sv
// Scoreboard bench for serial_sub4: stimulus pushes expected
// results, a monitor pops and compares on each accepted output.
module tb_serial_sub4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         busy;

  logic rand_rdy = 1'b0;
  logic rdy_ctl = 1'b1;
  int   cyc = 0;
  int   acc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [W:0] exp_q[$];

  serial_sub4 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a_i),
    .b        (b_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .borrow   (borrow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #2;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    else out_ready = rdy_ctl;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  initial begin : monitor
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %0h want none",
                   {borrow, diff});
        end else begin
          e = exp_q.pop_front();
          chk("result", {27'd0, borrow, diff}, {27'd0, e});
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] x,
                      input logic [W-1:0] y,
                      input bit push);
    int n;
    logic [W-1:0] dd;
    n = 0;
    a_i = x;
    b_i = y;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) fail("send_timeout");
    dd = x - y;
    if (push) exp_q.push_back({(x < y), dd});
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(output int lat, output bit hold_ok);
    int n;
    n = 0;
    hold_ok = 1'b1;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 50) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) hold_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail("out_valid_timeout");
    lat = cyc - acc;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) fail("drain_timeout");
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } vec_t;

  vec_t vecs[5] = '{
    '{4'd3, 4'd9}, '{4'd0, 4'd0}, '{4'd15, 4'd15},
    '{4'd0, 4'd1}, '{4'd7, 4'd2}
  };

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin : stim
    int lat;
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    send(4'd9, 4'd3, 1'b1);
    wait_ov(lat, ok);
    chk("latency", lat, W);
    chk("busy_hold", ok, 1);
    @(negedge clk);
    chk("post_ov_drop", out_valid, 0);
    chk("post_in_ready", in_ready, 1);

    foreach (vecs[i]) send(vecs[i].x, vecs[i].y, 1'b1);
    drain(100);

    rdy_ctl = 1'b0;
    send(4'd12, 4'd5, 1'b1);
    wait_ov(lat, ok);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_diff", diff, 7);
      chk("bp_borrow", borrow, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rdy_ctl = 1'b1;
    @(negedge clk);
    chk("bp_still_valid", out_valid, 1);
    @(negedge clk);
    chk("bp_drop", out_valid, 0);
    drain(20);

    send(4'd8, 4'd2, 1'b1);
    @(posedge clk);
    #1;
    a_i = 4'd1;
    b_i = 4'd1;
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("busy_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_ov(lat, ok);
    chk("busy_ign_hold", ok, 1);
    drain(20);
    repeat (8) @(negedge clk);
    chk("busy_ign_q", exp_q.size(), 0);

    send(4'd9, 4'd4, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow, 0);
    chk("abort_in_ready", in_ready, 1);
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    chk("abort_no_pulse", ok, 1);
    send(4'd5, 4'd2, 1'b1);
    drain(20);

    rand_rdy = 1'b1;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        send(W'(x), W'(y), 1'b1);
    drain(400);
    rand_rdy = 1'b0;

    repeat (4) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
